// File: rtl/prores_packer_pkg.sv
// Shared types and helpers for the ProRes bit packer and the entropy coders that feed it.
package prores_packer_pkg;

    localparam int unsigned PRORES_CODE_W = 32;
    localparam int unsigned PRORES_OUT_W  = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DRAIN
    } packer_state_e;

    function automatic int unsigned bytes_of(input int unsigned fill);
        return fill >> 3;
    endfunction

    function automatic int unsigned round_up8(input int unsigned fill);
        return (fill + 32'd7) & ~32'd7;
    endfunction

endpackage

// File: rtl/prores_packer_out_reg.sv
// Single-entry output holding register: loads a word, holds it until the consumer takes it.
module prores_packer_out_reg #(
    parameter int unsigned OUT_W   = 64,
    parameter int unsigned BYTES_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ld_valid,
    input  logic [OUT_W-1:0]   ld_data,
    input  logic [BYTES_W-1:0] ld_bytes,
    input  logic               ld_last,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [OUT_W-1:0]   out_data,
    output logic [BYTES_W-1:0] out_bytes,
    output logic               out_last
);

    logic               valid_q, valid_d;
    logic [OUT_W-1:0]   data_q, data_d;
    logic [BYTES_W-1:0] bytes_q, bytes_d;
    logic               last_q, last_d;

    // A load always wins; the upstream only loads when empty or being drained.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        bytes_d = bytes_q;
        last_d  = last_q;
        if (ld_valid) begin
            valid_d = 1'b1;
            data_d  = ld_data;
            bytes_d = ld_bytes;
            last_d  = ld_last;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            bytes_q <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            bytes_q <= bytes_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_bytes = bytes_q;
    assign out_last  = last_q;

endmodule

// File: rtl/prores_bit_packer.sv
// Packs variable-length codewords MSB-first into fixed OUT_W-bit words, with slice flush/drain.
// Optional 0xFF/0x00 marker stuffing is built when PRORES_PACKER_BYTE_STUFF_EN is defined.
module prores_bit_packer
    import prores_packer_pkg::*;
#(
    parameter  int unsigned CODE_W  = PRORES_CODE_W,
    parameter  int unsigned OUT_W   = PRORES_OUT_W,
    localparam int unsigned LEN_W   = $clog2(CODE_W + 1),
    localparam int unsigned BYTES_W = $clog2(OUT_W / 8 + 1),
    localparam int unsigned ACC_W   = OUT_W + CODE_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CODE_W-1:0]  in_code,
    input  logic [LEN_W-1:0]   in_len,
    input  logic               in_flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic [BYTES_W-1:0] out_bytes,
    output logic               out_last,
    output logic [31:0]        total_bytes,
    output logic               busy
);

    localparam int unsigned NB     = OUT_W / 8;
    localparam int unsigned FILL_W = $clog2(ACC_W + 1);

    packer_state_e      state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d, acc_w, code_lj;
    logic [FILL_W-1:0]  fill_q, fill_d, fill_w, fill_r, used_bits;
    logic               pend_q, pend_d;
    logic               loaded_q, loaded_d;
    logic [31:0]        total_q, total_d;
    logic [LEN_W-1:0]   len_c;
    logic               accept, can_load, out_hs;
    int unsigned        flush_bytes;
    logic [OUT_W-1:0]   pk_src, pk_word;
    logic [BYTES_W-1:0] pk_avail, pk_out, pk_used;
    logic               pk_pend;
    logic               ld_valid, ld_last;
    logic [OUT_W-1:0]   ld_data;
    logic [BYTES_W-1:0] ld_bytes;

    assign in_ready = (state_q == IDLE || state_q == RUN) && (fill_q <= FILL_W'(OUT_W));
    assign accept   = in_valid && in_ready;
    assign can_load = !out_valid || out_ready;
    assign out_hs   = out_valid && out_ready;
    assign busy     = (state_q != IDLE) || (fill_q != '0) || out_valid;

    // Left-justify code[len-1:0]; the shift drops the ignored upper code bits.
    assign len_c   = (in_len > LEN_W'(CODE_W)) ? LEN_W'(CODE_W) : in_len;
    assign code_lj = {in_code, {OUT_W{1'b0}}} << (LEN_W'(CODE_W) - len_c);

    always_comb begin
        acc_w  = acc_q;
        fill_w = fill_q;
        if (accept) begin
            acc_w  = acc_q | (code_lj >> fill_q);
            fill_w = fill_q + FILL_W'(len_c);
        end
    end

    // Bits below fill are always zero, so rounding up is just a count change.
    assign fill_r      = FILL_W'(round_up8(32'(fill_q)));
    assign flush_bytes = bytes_of(32'(fill_r));

    always_comb begin
        pk_src   = acc_q[ACC_W-1 -: OUT_W];
        pk_avail = BYTES_W'(NB);
        if (state_q == IDLE || state_q == RUN) begin
            pk_src = acc_w[ACC_W-1 -: OUT_W];
        end else if (flush_bytes < NB) begin
            pk_avail = BYTES_W'(flush_bytes);
        end
    end

`ifdef PRORES_PACKER_BYTE_STUFF_EN
    // Walk output byte slots; a pending stuff slot emits 0x00 without consuming source.
    always_comb begin : stuff_bytes
        int unsigned used;
        int unsigned n;
        logic        pend;
        logic [7:0]  b;
        used    = 0;
        n       = 0;
        pend    = pend_q;
        b       = '0;
        pk_word = '0;
        for (int unsigned j = 0; j < NB; j++) begin
            if (pend) begin
                n    = n + 1;
                pend = 1'b0;
            end else if (used < 32'(pk_avail)) begin
                b       = 8'(pk_src >> (OUT_W - 8 - 8 * used));
                pk_word = pk_word | (OUT_W'(b) << (OUT_W - 8 - 8 * j));
                used    = used + 1;
                n       = n + 1;
                pend    = (b == 8'hFF);
            end
        end
        pk_used = BYTES_W'(used);
        pk_out  = BYTES_W'(n);
        pk_pend = pend;
    end
`else
    assign pk_word = pk_src;
    assign pk_out  = pk_avail;
    assign pk_used = pk_avail;
    assign pk_pend = 1'b0;
`endif

    assign used_bits = FILL_W'(pk_used) << 3;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        fill_d   = fill_q;
        pend_d   = pend_q;
        loaded_d = loaded_q;
        total_d  = total_q;
        ld_valid = 1'b0;
        ld_data  = pk_word;
        ld_bytes = pk_out;
        ld_last  = 1'b0;

        if (out_hs) begin
            total_d = out_last ? '0 : total_q + 32'(out_bytes);
        end

        case (state_q)
            IDLE, RUN: begin
                acc_d  = acc_w;
                fill_d = fill_w;
                if (accept && in_flush) begin
                    state_d = FLUSH;
                end else if (accept && len_c != '0) begin
                    state_d = RUN;
                end
                // A flushing accept leaves word emission to FLUSH so the tail word carries out_last.
                if (!(accept && in_flush) && fill_w >= FILL_W'(OUT_W) && can_load) begin
                    ld_valid = 1'b1;
                    acc_d    = acc_w << used_bits;
                    fill_d   = fill_w - used_bits;
                    pend_d   = pk_pend;
                end
            end
            FLUSH: begin
                fill_d = fill_r;
                if (flush_bytes > 32'(pk_used)) begin
                    if (can_load) begin
                        ld_valid = 1'b1;
                        acc_d    = acc_q << used_bits;
                        fill_d   = fill_r - used_bits;
                        pend_d   = pk_pend;
                    end
                end else begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!loaded_q) begin
                    if (can_load) begin
                        ld_valid = 1'b1;
                        ld_last  = 1'b1;
                        acc_d    = '0;
                        fill_d   = '0;
                        pend_d   = 1'b0;
                        loaded_d = 1'b1;
                    end
                end else if (out_hs && out_last) begin
                    state_d  = IDLE;
                    loaded_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            fill_q   <= '0;
            pend_q   <= 1'b0;
            loaded_q <= 1'b0;
            total_q  <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            fill_q   <= fill_d;
            pend_q   <= pend_d;
            loaded_q <= loaded_d;
            total_q  <= total_d;
        end
    end

    assign total_bytes = total_q;

    prores_packer_out_reg #(
        .OUT_W  (OUT_W),
        .BYTES_W(BYTES_W)
    ) u_out_reg (
        .clock    (clock),
        .reset    (reset),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_bytes (ld_bytes),
        .ld_last  (ld_last),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_bytes(out_bytes),
        .out_last (out_last)
    );

endmodule

// File: tb/tb_prores_bit_packer.sv
// Directed bench for prores_bit_packer (CODE_W=32, OUT_W=64, stuffing off).
module tb_prores_bit_packer;

    localparam int unsigned CODE_W = 32;
    localparam int unsigned OUT_W  = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_code;
    logic [5:0]  in_len;
    logic        in_flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [3:0]  out_bytes;
    logic        out_last;
    logic [31:0] total_bytes;
    logic        busy;

    prores_bit_packer #(
        .CODE_W(CODE_W),
        .OUT_W (OUT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .in_len     (in_len),
        .in_flush   (in_flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_bytes  (out_bytes),
        .out_last   (out_last),
        .total_bytes(total_bytes),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        iv;
        logic [31:0] code;
        logic [5:0]  len;
        logic        fl;
        logic        e_ov;
        logic        e_ir;
        logic        e_busy;
        logic [31:0] e_tot;
        logic [63:0] e_data;
        logic [3:0]  e_bytes;
        logic        e_last;
    } vec_t;

    vec_t        vq[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          n_acc;
    int          n_words;
    int          n_seen;
    int          idx;
    logic        sent;
    logic        got_last;
    logic [63:0] cap_data[4];
    logic [3:0]  cap_bytes[4];
    logic        cap_last[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic iv, input logic [31:0] code, input logic [5:0] len, input logic fl,
                       input logic e_ov, input logic e_ir, input logic e_busy, input logic [31:0] e_tot,
                       input logic [63:0] e_data = 64'd0, input logic [3:0] e_bytes = 4'd0,
                       input logic e_last = 1'b0);
        vec_t v;
        v.iv = iv; v.code = code; v.len = len; v.fl = fl;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_busy = e_busy; v.e_tot = e_tot;
        v.e_data = e_data; v.e_bytes = e_bytes; v.e_last = e_last;
        vq.push_back(v);
    endtask

    initial begin
        // Each record: expected outputs seen before the edge, then inputs applied for that edge.
        for (int i = 0; i < 5; i++) add(1'b0, 32'h0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 8; i++) add(1'b1, 32'hAB, 6'd8, 1'b0, 1'b0, 1'b1, (i != 0), 32'd0);
        add(1'b0, 32'h0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd0, 64'hABAB_ABAB_ABAB_ABAB, 4'd8, 1'b0);
        add(1'b1, 32'h5, 6'd3, 1'b0, 1'b0, 1'b1, 1'b1, 32'd8);
        add(1'b1, 32'h0, 6'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'd8);
        add(1'b0, 32'h0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd8);
        add(1'b0, 32'h0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd8);
        add(1'b0, 32'h0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd8, 64'hA000_0000_0000_0000, 4'd1, 1'b1);
        add(1'b0, 32'h0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        // in_len=40 clamps to 32
        add(1'b1, 32'h1234_5678, 6'd40, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        add(1'b1, 32'h0, 6'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'd0);
        add(1'b0, 32'h0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        add(1'b0, 32'h0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        add(1'b0, 32'h0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 64'h1234_5678_0000_0000, 4'd4, 1'b1);
        // flush with nothing buffered gives an empty last word
        add(1'b1, 32'h0000_DEAD, 6'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        add(1'b0, 32'h0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        add(1'b0, 32'h0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        add(1'b0, 32'h0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 64'h0, 4'd0, 1'b1);
        // upper code bits above in_len are ignored; 7 bits pad to one byte
        add(1'b1, 32'hFFFF_FFFF, 6'd4, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        add(1'b1, 32'h0000_0002, 6'd3, 1'b1, 1'b0, 1'b1, 1'b1, 32'd0);
        add(1'b0, 32'h0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        add(1'b0, 32'h0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        add(1'b0, 32'h0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 64'hF400_0000_0000_0000, 4'd1, 1'b1);
        add(1'b0, 32'h0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_code   = '0;
        in_len    = '0;
        in_flush  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        foreach (vq[i]) begin
            @(negedge clock);
            vectors++;
            check($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(vq[i].e_ov));
            check($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(vq[i].e_ir));
            check($sformatf("vec%0d busy", i), 64'(busy), 64'(vq[i].e_busy));
            check($sformatf("vec%0d total_bytes", i), 64'(total_bytes), 64'(vq[i].e_tot));
            if (vq[i].e_ov) begin
                check($sformatf("vec%0d out_data", i), out_data, vq[i].e_data);
                check($sformatf("vec%0d out_bytes", i), 64'(out_bytes), 64'(vq[i].e_bytes));
                check($sformatf("vec%0d out_last", i), 64'(out_last), 64'(vq[i].e_last));
            end
            in_valid = vq[i].iv;
            in_code  = vq[i].code;
            in_len   = vq[i].len;
            in_flush = vq[i].fl;
        end

        // Backpressure: only 5 full-length codes fit with the output stalled.
        @(negedge clock);
        in_valid  = 1'b1;
        in_code   = 32'h1111_1111;
        in_len    = 6'd32;
        in_flush  = 1'b0;
        out_ready = 1'b0;
        n_acc     = 0;
        for (int c = 0; c < 12; c++) begin
            if (in_ready) n_acc++;
            @(negedge clock);
        end
        vectors++;
        check("stall accepts", 64'(n_acc), 64'd5);
        check("stall in_ready", 64'(in_ready), 64'd0);
        check("stall out_valid", 64'(out_valid), 64'd1);

        in_valid  = 1'b0;
        out_ready = 1'b1;
        sent      = 1'b0;
        got_last  = 1'b0;
        n_words   = 0;
        for (int c = 0; c < 30 && !got_last; c++) begin
            if (out_valid && n_words < 4) begin
                cap_data[n_words]  = out_data;
                cap_bytes[n_words] = out_bytes;
                cap_last[n_words]  = out_last;
                n_words++;
                if (out_last) got_last = 1'b1;
            end
            in_valid = 1'b0;
            if (!sent && in_ready) begin
                in_valid = 1'b1;
                in_code  = 32'h0;
                in_len   = 6'd0;
                in_flush = 1'b1;
                sent     = 1'b1;
            end
            @(negedge clock);
        end
        in_valid = 1'b0;
        in_flush = 1'b0;
        vectors++;
        check("drain word count", 64'(n_words), 64'd3);
        if (n_words == 3) begin
            check("drain w0 data", cap_data[0], 64'h1111_1111_1111_1111);
            check("drain w0 bytes", 64'(cap_bytes[0]), 64'd8);
            check("drain w0 last", 64'(cap_last[0]), 64'd0);
            check("drain w1 data", cap_data[1], 64'h1111_1111_1111_1111);
            check("drain w1 last", 64'(cap_last[1]), 64'd0);
            check("drain w2 data", cap_data[2], 64'h1111_1111_0000_0000);
            check("drain w2 bytes", 64'(cap_bytes[2]), 64'd4);
            check("drain w2 last", 64'(cap_last[2]), 64'd1);
        end
        check("drain busy", 64'(busy), 64'd0);
        check("drain total_bytes", 64'(total_bytes), 64'd0);

        // Reset while stuck in FLUSH with a held output word.
        out_ready = 1'b0;
        idx       = 0;
        for (int c = 0; c < 20 && idx < 5; c++) begin
            in_valid = 1'b0;
            in_flush = 1'b0;
            if (in_ready) begin
                in_valid = 1'b1;
                in_code  = (idx == 4) ? 32'h3333_3333 : 32'h2222_2222;
                in_len   = 6'd32;
                in_flush = (idx == 4);
                idx++;
            end
            @(negedge clock);
        end
        in_valid = 1'b0;
        in_flush = 1'b0;
        @(negedge clock);
        vectors++;
        check("preflush codes sent", 64'(idx), 64'd5);
        check("preflush out_valid", 64'(out_valid), 64'd1);
        check("preflush in_ready", 64'(in_ready), 64'd0);
        check("preflush busy", 64'(busy), 64'd1);

        reset = 1'b1;
        @(negedge clock);
        vectors++;
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst in_ready", 64'(in_ready), 64'd1);
        check("rst total_bytes", 64'(total_bytes), 64'd0);
        reset     = 1'b0;
        out_ready = 1'b1;
        n_seen    = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) n_seen++;
            @(negedge clock);
        end
        vectors++;
        check("post-reset words emitted", 64'(n_seen), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
